sdf_stage_ctrl: RTL

Parametrised control unit for one radix-2 single-path delay-feedback (SDF) butterfly stage of the FFT pipeline. It tracks the streaming sample position and sequences the stage through fill, sum and difference phases. It drives the stage's delay-line mux select and issues the twiddle factor W_2D^n for each difference-phase cycle. It replaces the fixed-span per-stage controllers; any stage of an N-point pipeline is one instance with its own STAGE_SPAN.

---
 rtl/fft_pkg.sv | 54 +++++
 rtl/twiddle_rom.sv | 31 +++
 rtl/sdf_stage_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: stage phase encoding, twiddle Q-format and the
// elaboration-time twiddle generator (floor rule, Q1.(TW_W-2)).
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRST   = 2'd1,
    ST_SECOND  = 2'd2,
    ST_WAITING = 2'd3
  } state_t;

  localparam int     Q_FRAC = 28;
  localparam longint PI_Q   = 64'sd843314857;  // pi in Q28

  function automatic int tw_one(input int tw_w);
    return 1 << (tw_w - 2);
  endfunction

  // sin or cos of 2*pi*m/n for 0 <= m < n/4, Taylor series in Q28
  function automatic longint sincos_q(input int m, input int n, input bit want_sin);
    longint x, x2, term, sum;
    x  = (64'sd2 * PI_Q * longint'(m)) / longint'(n);
    x2 = (x * x) >>> Q_FRAC;
    term = want_sin ? x : (64'sd1 <<< Q_FRAC);
    sum  = term;
    for (int i = 1; i < 10; i++) begin
      if (want_sin)
        term = -(((term * x2) >>> Q_FRAC) / longint'((2 * i) * (2 * i + 1)));
      else
        term = -(((term * x2) >>> Q_FRAC) / longint'((2 * i - 1) * (2 * i)));
      sum = sum + term;
    end
    return sum;
  endfunction

  // W_n^k component for k in 0..n/2-1; exact quadrant points avoid rounding
  // noise pushing floor() across an integer.
  function automatic int tw_val(input int k, input int n, input int tw_w, input bit imag);
    longint c, s, one;
    if (4 * k == n) begin
      c = 64'sd0;
      s = 64'sd1 <<< Q_FRAC;
    end else if (4 * k < n) begin
      c = sincos_q(k, n, 1'b0);
      s = sincos_q(k, n, 1'b1);
    end else begin
      c = -sincos_q(n / 2 - k, n, 1'b0);
      s = sincos_q(n / 2 - k, n, 1'b1);
    end
    one = longint'(tw_one(tw_w));
    return imag ? int'((-(one * s)) >>> Q_FRAC) : int'((one * c) >>> Q_FRAC);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Constant twiddle table W_N^k, k = 0..N/2-1; purely combinational lookup.
// conj negates the imaginary part for inverse transforms.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N_POINT = 32,
  parameter int TW_W    = 8,
  localparam int KW     = $clog2(N_POINT / 2)
) (
  input  logic [KW-1:0]          k,
  input  logic                   conj,
  output logic signed [TW_W-1:0] wn_r,
  output logic signed [TW_W-1:0] wn_i
);

  logic signed [TW_W-1:0] tab_r [N_POINT/2];
  logic signed [TW_W-1:0] tab_i [N_POINT/2];

  for (genvar g = 0; g < N_POINT / 2; g++) begin : g_tab
    localparam int WR = tw_val(g, N_POINT, TW_W, 1'b0);
    localparam int WI = tw_val(g, N_POINT, TW_W, 1'b1);
    assign tab_r[g] = TW_W'(WR);
    assign tab_i[g] = TW_W'(WI);
  end

  always_comb begin
    wn_r = tab_r[k];
    wn_i = conj ? -tab_i[k] : tab_i[k];
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Radix-2 SDF stage sequencer: IDLE/WAITING/FIRST/SECOND phases, twiddle per
// SECOND cycle, data_out one cycle behind data_in. Optional CTRL_INVERSE_EN.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_POINT    = 32,
  parameter int STAGE_SPAN = 4,
  parameter int DATA_W     = 15,
  parameter int TW_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
`ifdef CTRL_INVERSE_EN
  input  logic                     inverse_i,
`endif
  output logic                     valid_o,
  output logic [1:0]               state,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i,
  output logic signed [TW_W-1:0]   WN_r,
  output logic signed [TW_W-1:0]   WN_i,
  output logic                     err_o
);

  localparam int D   = STAGE_SPAN;
  localparam int CW  = $clog2(3 * D + 1);
  localparam int KW  = $clog2(N_POINT / 2);
  localparam int KSH = $clog2(N_POINT / (2 * D));
  localparam logic [CW-1:0] CNT_D  = CW'(D);
  localparam logic [CW-1:0] CNT_2D = CW'(2 * D);
  localparam logic [CW-1:0] CNT_3D = CW'(3 * D);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_d;
  logic            inv_q, inv_d, inv_in;
  logic [CW-1:0]   tw_n;
  logic [KW-1:0]   tw_k;
  logic signed [TW_W-1:0] rom_r, rom_i;

`ifdef CTRL_INVERSE_EN
  assign inv_in = inverse_i;
`else
  assign inv_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_o      <= 1'b0;
      inv_q      <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_o      <= err_d;
      inv_q      <= inv_d;
      data_out_r <= data_in_r;
      data_out_i <= data_in_i;
    end
  end

  // valid_i in the last FIRST cycle already belongs to the next group
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    inv_d   = inv_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          state_d = ST_WAITING;
          cnt_d   = CW'(1);
          inv_d   = inv_in;
        end
      end
      ST_WAITING: begin
        if (!valid_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_D) state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (!valid_i && cnt_q != CNT_2D) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_2D) state_d = ST_SECOND;
        end
      end
      ST_SECOND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_3D) begin
          if (valid_i) begin
            state_d = ST_FIRST;
            cnt_d   = CNT_D + 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tw_n = cnt_q - (CNT_2D + 1'b1);
  assign tw_k = KW'(tw_n) << KSH;

  twiddle_rom #(
    .N_POINT(N_POINT),
    .TW_W   (TW_W)
  ) u_rom (
    .k   (tw_k),
    .conj(inv_q),
    .wn_r(rom_r),
    .wn_i(rom_i)
  );

  assign state   = state_q;
  assign valid_o = (state_q == ST_FIRST) || (state_q == ST_SECOND);
  assign WN_r    = (state_q == ST_SECOND) ? rom_r : '0;
  assign WN_i    = (state_q == ST_SECOND) ? rom_i : '0;

endmodule
